apple_spawner: RTL and testbench

Generates a new pseudo-random, grid-aligned apple position for the snake game each time the snake eats the apple. It sits directly upstream of the VGA draw/move FSM, which consumes its `apple_x`/`apple_y` outputs and draws the 10x10 apple there. A free-running 16-bit LFSR supplies candidate positions. Candidates that fall off-grid or overlap the snake head are rejected and retried, with a guaranteed-safe fallback after a bounded number of tries.

---
 rtl/apple_spawner.sv | 171 +++++++++++++++++
 tb/tb_apple_spawner.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/apple_spawner.sv
// Picks a pseudo-random, grid-aligned apple position for the snake game,
// retrying candidates that are off-grid or on the head, with a safe corner fallback.
module apple_spawner #(
    parameter logic [15:0] SEED      = 16'hACE1,
    parameter int unsigned SIZE      = 10,
    parameter int unsigned COLS      = 16,
    parameter int unsigned ROWS      = 12,
    parameter int unsigned MAX_TRIES = 7,
    parameter logic [7:0]  INIT_X    = 8'd80,
    parameter logic [6:0]  INIT_Y    = 7'd60
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       req,
    input  logic [7:0] head_x,
    input  logic [6:0] head_y,
    output logic [7:0] apple_x,
    output logic [6:0] apple_y,
    output logic       valid,
    output logic       busy
);

    localparam int unsigned LFSR_W = 16;
    localparam int unsigned X_W    = 8;
    localparam int unsigned Y_W    = 7;
    localparam int unsigned CELL_W = 4;
    localparam int unsigned TRY_W  = 4;
    localparam int unsigned DIFF_W = 9;

    localparam logic [LFSR_W-1:0] TAPS      = 16'hB400;
    localparam logic [TRY_W-1:0]  TRY_LAST  = TRY_W'(MAX_TRIES);
    localparam logic [DIFF_W-1:0] SIZE_D    = DIFF_W'(SIZE);
    localparam logic [X_W-1:0]    MID_X     = X_W'((COLS / 2) * SIZE);
    localparam logic [Y_W-1:0]    MID_Y     = Y_W'((ROWS / 2) * SIZE);
    localparam logic [X_W-1:0]    FAR_X     = X_W'((COLS - 1) * SIZE);
    localparam logic [Y_W-1:0]    FAR_Y     = Y_W'((ROWS - 1) * SIZE);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SAMPLE = 2'd1,
        CHECK  = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [LFSR_W-1:0]   lfsr_q, lfsr_d;
    logic [TRY_W-1:0]    tries_q, tries_d;
    logic [CELL_W-1:0]   cand_col_q, cand_col_d;
    logic [CELL_W-1:0]   cand_row_q, cand_row_d;
    logic [X_W-1:0]      head_x_q, head_x_d;
    logic [Y_W-1:0]      head_y_q, head_y_d;
    logic [X_W-1:0]      apple_x_q, apple_x_d;
    logic [Y_W-1:0]      apple_y_q, apple_y_d;
    logic                valid_q, valid_d;
    logic                busy_q, busy_d;

    logic [X_W-1:0]           cand_x;
    logic [Y_W-1:0]           cand_y;
    logic signed [DIFF_W-1:0] dx, dy;
    logic [DIFF_W-1:0]        adx, ady;
    logic                     off_grid, overlap, reject;
    logic [X_W-1:0]           fb_x;
    logic [Y_W-1:0]           fb_y;

    // Shift-add multiply of a cell index by SIZE.
    function automatic logic [X_W-1:0] times_size(input logic [CELL_W-1:0] c);
        logic [X_W-1:0] acc;
        acc = '0;
        for (int i = 0; i < int'(X_W); i++) begin
            if (SIZE[i]) acc = acc + (X_W'(c) << i);
        end
        return acc;
    endfunction

    // Candidate evaluation against the head captured in SAMPLE.
    always_comb begin
        cand_x   = times_size(cand_col_q);
        cand_y   = Y_W'(times_size(cand_row_q));
        dx       = $signed({1'b0, cand_x}) - $signed({1'b0, head_x_q});
        dy       = $signed({2'b0, cand_y}) - $signed({2'b0, head_y_q});
        adx      = dx[DIFF_W-1] ? DIFF_W'(-dx) : DIFF_W'(dx);
        ady      = dy[DIFF_W-1] ? DIFF_W'(-dy) : DIFF_W'(dy);
        off_grid = (32'(cand_col_q) >= COLS) || (32'(cand_row_q) >= ROWS);
        overlap  = (adx < SIZE_D) && (ady < SIZE_D);
        reject   = off_grid || overlap;
        fb_x     = (head_x_q >= MID_X) ? '0 : FAR_X;
        fb_y     = (head_y_q >= MID_Y) ? '0 : FAR_Y;
    end

    always_comb begin
        state_d    = state_q;
        tries_d    = tries_q;
        cand_col_d = cand_col_q;
        cand_row_d = cand_row_q;
        head_x_d   = head_x_q;
        head_y_d   = head_y_q;
        apple_x_d  = apple_x_q;
        apple_y_d  = apple_y_q;
        lfsr_d     = {1'b0, lfsr_q[LFSR_W-1:1]} ^ (lfsr_q[0] ? TAPS : '0);

        case (state_q)
            IDLE: begin
                if (req) begin
                    state_d = SAMPLE;
                    tries_d = '0;
                end
            end
            SAMPLE: begin
                cand_col_d = lfsr_q[3:0];
                cand_row_d = lfsr_q[7:4];
                head_x_d   = head_x;
                head_y_d   = head_y;
                state_d    = CHECK;
            end
            CHECK: begin
                if (!reject) begin
                    apple_x_d = cand_x;
                    apple_y_d = cand_y;
                    state_d   = DONE;
                end else if (tries_q == TRY_LAST) begin
                    apple_x_d = fb_x;
                    apple_y_d = fb_y;
                    state_d   = DONE;
                end else begin
                    tries_d = tries_q + TRY_W'(1);
                    state_d = SAMPLE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Status flags registered from the upcoming state so they track it exactly.
        valid_d = (state_d == DONE);
        busy_d  = (state_d != IDLE);
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q    <= IDLE;
            lfsr_q     <= SEED;
            tries_q    <= '0;
            cand_col_q <= '0;
            cand_row_q <= '0;
            head_x_q   <= '0;
            head_y_q   <= '0;
            apple_x_q  <= INIT_X;
            apple_y_q  <= INIT_Y;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            lfsr_q     <= lfsr_d;
            tries_q    <= tries_d;
            cand_col_q <= cand_col_d;
            cand_row_q <= cand_row_d;
            head_x_q   <= head_x_d;
            head_y_q   <= head_y_d;
            apple_x_q  <= apple_x_d;
            apple_y_q  <= apple_y_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
        end
    end

    assign apple_x = apple_x_q;
    assign apple_y = apple_y_q;
    assign valid   = valid_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_apple_spawner.sv
// Bench for apple_spawner: per-cycle comparison against a spawn-outcome model,
// plus literal checks for reset, fallback corners, busy handling and a random soak.
module tb_apple_spawner;

    localparam int MT = 7;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic       req = 1'b0;
    logic [7:0] head_x = 8'd80;
    logic [6:0] head_y = 7'd60;
    logic [7:0] apple_x;
    logic [6:0] apple_y;
    logic       valid, busy;

    logic       req_fb = 1'b0;
    logic [7:0] fb_hx = 8'd0;
    logic [6:0] fb_hy = 7'd0;
    logic [7:0] fb_apple_x;
    logic [6:0] fb_apple_y;
    logic       fb_valid, fb_busy;

    apple_spawner dut (
        .Clock(Clock), .Reset(Reset), .req(req), .head_x(head_x), .head_y(head_y),
        .apple_x(apple_x), .apple_y(apple_y), .valid(valid), .busy(busy)
    );

    apple_spawner #(.MAX_TRIES(0)) dut_fb (
        .Clock(Clock), .Reset(Reset), .req(req_fb), .head_x(fb_hx), .head_y(fb_hy),
        .apple_x(fb_apple_x), .apple_y(fb_apple_y), .valid(fb_valid), .busy(fb_busy)
    );

    always #5 Clock = ~Clock;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        return {1'b0, l[15:1]} ^ (l[0] ? 16'hB400 : 16'h0000);
    endfunction

    // Outcome of a whole spawn: number of rejections n and final position.
    function automatic void predict(input logic [15:0] l0, input int hx, input int hy,
                                    input int max_tries,
                                    output int n, output int px, output int py);
        logic [15:0] l;
        int col, row, cx, cy, ax, ay;
        l = lfsr_step(l0);
        for (int k = 0; k <= max_tries; k++) begin
            col = int'(l[3:0]);
            row = int'(l[7:4]);
            cx  = col * 10;
            cy  = row * 10;
            ax  = (cx > hx) ? cx - hx : hx - cx;
            ay  = (cy > hy) ? cy - hy : hy - cy;
            if (row < 12 && col < 16 && !(ax < 10 && ay < 10)) begin
                n = k; px = cx; py = cy;
                return;
            end
            l = lfsr_step(lfsr_step(l));
        end
        n  = max_tries;
        px = (hx >= 80) ? 0 : 150;
        py = (hy >= 60) ? 0 : 110;
    endfunction

    logic [15:0] m_lfsr;
    int          m_rem;
    int          m_px, m_py;
    int          exp_x = 80, exp_y = 60;
    int          exp_valid = 0, exp_busy = 0;

    // Model: remaining busy cycles of the current spawn and the result it lands on.
    always @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            m_lfsr    = 16'hACE1;
            m_rem     = 0;
            exp_x     = 80;
            exp_y     = 60;
            exp_valid = 0;
            exp_busy  = 0;
        end else begin
            int n;
            if (m_rem > 0) begin
                m_rem--;
            end else if (req) begin
                predict(m_lfsr, int'(head_x), int'(head_y), MT, n, m_px, m_py);
                m_rem = 3 + 2 * n;
            end
            exp_busy  = (m_rem > 0) ? 1 : 0;
            exp_valid = (m_rem == 1) ? 1 : 0;
            if (m_rem == 1) begin
                exp_x = m_px;
                exp_y = m_py;
            end
            m_lfsr = lfsr_step(m_lfsr);
        end
    end

    always @(negedge Clock) begin
        if (!Reset) begin
            chk("cyc_valid", int'(valid), exp_valid);
            chk("cyc_busy", int'(busy), exp_busy);
            chk("cyc_apple_x", int'(apple_x), exp_x);
            chk("cyc_apple_y", int'(apple_y), exp_y);
        end
    end

    // Issue one request from IDLE; returns latency in cycles and the resulting apple.
    task automatic spawn(input int hx, input int hy, output int lat, output int ax, output int ay);
        head_x = 8'(hx);
        head_y = 7'(hy);
        req = 1'b1;
        @(posedge Clock); #1;
        req = 1'b0;
        lat = 1;
        while (!valid && lat < 40) begin
            @(posedge Clock); #1;
            lat++;
        end
        if (!valid) chk("spawn_timeout", 0, 1);
        ax = int'(apple_x);
        ay = int'(apple_y);
        @(posedge Clock); #1;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        @(posedge Clock); #1;
        @(posedge Clock); #1;
        Reset = 1'b0;
    endtask

    // Fallback instance: request on a cycle whose first candidate is off-grid.
    task automatic fb_run(input int hx, input int hy, input int ex, input int ey);
        logic [15:0] nx;
        int lat;
        bit found;
        fb_hx = 8'(hx);
        fb_hy = 7'(hy);
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            nx = lfsr_step(m_lfsr);
            if (nx[7:4] >= 4'd12) found = 1'b1;
            else begin
                @(posedge Clock); #1;
            end
        end
        if (!found) chk("fb_search", 0, 1);
        req_fb = 1'b1;
        @(posedge Clock); #1;
        req_fb = 1'b0;
        lat = 1;
        while (!fb_valid && lat < 40) begin
            @(posedge Clock); #1;
            lat++;
        end
        chk("fb_latency", lat, 3);
        chk("fb_apple_x", int'(fb_apple_x), ex);
        chk("fb_apple_y", int'(fb_apple_y), ey);
        @(posedge Clock); #1;
        chk("fb_busy_after", int'(fb_busy), 0);
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat, ax, ay, nvalid, hx, hy, ddx, ddy;

        // Reset state held with req low
        do_reset();
        chk("rst_apple_x", int'(apple_x), 80);
        chk("rst_apple_y", int'(apple_y), 60);
        chk("rst_valid", int'(valid), 0);
        chk("rst_busy", int'(busy), 0);
        repeat (20) @(posedge Clock);
        #1;
        chk("idle_apple_x", int'(apple_x), 80);
        chk("idle_busy", int'(busy), 0);

        // First spawn straight after reset: candidate from lfsr 0xE270 -> (0,70)
        Reset = 1'b1;
        @(posedge Clock); #1;
        Reset = 1'b0;
        spawn(80, 60, lat, ax, ay);
        chk("pin1_latency", lat, 3);
        chk("pin1_x", ax, 0);
        chk("pin1_y", ay, 70);

        // Head on (0,70) rejects it; next candidate 0x389C -> (120,90)
        Reset = 1'b1;
        @(posedge Clock); #1;
        Reset = 1'b0;
        spawn(0, 70, lat, ax, ay);
        chk("pin2_latency", lat, 5);
        chk("pin2_x", ax, 120);
        chk("pin2_y", ay, 90);

        // Second req while busy is dropped
        head_x = 8'd30;
        head_y = 7'd40;
        req = 1'b1;
        @(posedge Clock); #1;
        req = 1'b0;
        @(posedge Clock); #1;
        req = 1'b1;
        @(posedge Clock); #1;
        req = 1'b0;
        nvalid = 0;
        for (int i = 0; i < 30; i++) begin
            if (valid) nvalid++;
            @(posedge Clock); #1;
        end
        chk("busy_one_valid", nvalid, 1);

        // Reset while in CHECK
        head_x = 8'd50;
        head_y = 7'd50;
        req = 1'b1;
        @(posedge Clock); #1;
        req = 1'b0;
        @(posedge Clock); #1;
        Reset = 1'b1;
        #1;
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_valid", int'(valid), 0);
        chk("midrst_x", int'(apple_x), 80);
        chk("midrst_y", int'(apple_y), 60);
        @(posedge Clock); #1;
        Reset = 1'b0;
        spawn(50, 50, lat, ax, ay);
        chk("midrst_lat_odd", lat % 2, 1);
        chk("midrst_lat_range", int'(lat >= 3 && lat <= 17), 1);

        // Fallback corners with MAX_TRIES = 0
        fb_run(39, 59, 150, 110);
        fb_run(120, 90, 0, 0);

        // Random soak
        for (int i = 0; i < 2000; i++) begin
            hx = int'($urandom_range(0, 150));
            hy = int'($urandom_range(0, 110));
            spawn(hx, hy, lat, ax, ay);
            ddx = (ax > hx) ? ax - hx : hx - ax;
            ddy = (ay > hy) ? ay - hy : hy - ay;
            chk("soak_x_grid", ax % 10, 0);
            chk("soak_y_grid", ay % 10, 0);
            chk("soak_in_range", int'(ax <= 150 && ay <= 110), 1);
            chk("soak_no_overlap", int'(ddx < 10 && ddy < 10), 0);
            chk("soak_lat_odd", lat % 2, 1);
            chk("soak_lat_range", int'(lat >= 3 && lat <= 17), 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
